// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// regbank_pkg : shared widths and requester IDs for the register-bank control
// Revision    : 1.0
// ============================================================================
package regbank_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NREG   = 2 ** ADDR_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-input round-robin arbiter, one grant per cycle
// Revision: 1.0
// ============================================================================
module rr_arb2
    import regbank_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    req_id_t r_last;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0 = req0 && (!req1 || (r_last == REQ_LD));
        gnt1 = req1 && !gnt0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_LD;
        end else if (gnt0) begin
            r_last <= REQ_ALU;
        end else if (gnt1) begin
            r_last <= REQ_LD;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regbank_ctrl.sv
`default_nettype none
// ============================================================================
// regbank_ctrl : write-port arbiter, registered write stage and busy scoreboard
// Revision     : 1.0
// ============================================================================
module regbank_ctrl
    import regbank_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              chk_busy1,
    output logic              chk_busy2,
    output logic              rb_we,
    output logic [ADDR_W-1:0] rb_dest,
    output logic [DATA_W-1:0] rb_din,
    output logic [ADDR_W:0]   pend_cnt
);

    logic              w_gnt0;
    logic              w_gnt1;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_set;
    logic [NREG-1:0]   w_clr;
    logic [NREG-1:0]   w_busy_nxt;
    logic [ADDR_W:0]   w_pend_nxt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (wr0_valid),
        .req1  (wr1_valid),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign wr0_ready = w_gnt0;
    assign wr1_ready = w_gnt1;
    assign rsv_ready = !r_busy[rsv_addr] && !flush;
    assign chk_busy1 = r_busy[chk_addr1];
    assign chk_busy2 = r_busy[chk_addr2];

    // Busy clears on the edge the bank captures the write.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (rsv_valid && rsv_ready) begin
            w_set[rsv_addr] = 1'b1;
        end
        if (rb_we) begin
            w_clr[rb_dest] = 1'b1;
        end
        w_busy_nxt = flush ? '0 : ((r_busy & ~w_clr) | w_set);
    end

    // Count computed from the next state so pend_cnt tracks busy cycle for cycle.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_pend_nxt = w_pend_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            pend_cnt <= '0;
        end else begin
            r_busy   <= w_busy_nxt;
            pend_cnt <= w_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_we   <= 1'b0;
            rb_dest <= '0;
            rb_din  <= '0;
        end else begin
            rb_we <= w_gnt0 || w_gnt1;
            if (w_gnt0) begin
                rb_dest <= wr0_addr;
                rb_din  <= wr0_data;
            end else if (w_gnt1) begin
                rb_dest <= wr1_addr;
                rb_din  <= wr1_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regbank_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regbank_ctrl : directed stimulus with a write-stage scoreboard monitor
// Revision        : 1.0
// ============================================================================
module tb_regbank_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          wr0_valid, wr1_valid;
    logic [AW-1:0] wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ready;
    logic          flush;
    logic [AW-1:0] chk_addr1, chk_addr2;
    logic          chk_busy1, chk_busy2;
    logic          rb_we;
    logic [AW-1:0] rb_dest;
    logic [DW-1:0] rb_din;
    logic [AW:0]   pend_cnt;

    int checks   = 0;
    int failures = 0;

    logic [AW+DW-1:0] exp_q[$];

    regbank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr0_valid (wr0_valid),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr0_ready (wr0_ready),
        .wr1_valid (wr1_valid),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .wr1_ready (wr1_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .chk_busy1 (chk_busy1),
        .chk_busy2 (chk_busy2),
        .rb_we     (rb_we),
        .rb_dest   (rb_dest),
        .rb_din    (rb_din),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every committed bank write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && rb_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(rb_dest), 64'hDEAD);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("wr_dest", 64'(rb_dest), 64'(e[AW+DW-1:DW]));
                chk("wr_din",  64'(rb_din),  64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
        chk_addr1 = '0; chk_addr2 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_rb_we",   64'(rb_we),    64'd0);
        chk("rst_rb_dest", 64'(rb_dest),  64'd0);
        chk("rst_rb_din",  64'(rb_din),   64'd0);
        chk("rst_pend",    64'(pend_cnt), 64'd0);
        chk("rst_busy1",   64'(chk_busy1), 64'd0);

        // Dual contention: grants alternate starting with requester 0
        next_cycle();
        wr0_valid = 1'b1; wr0_addr = 4'd4; wr0_data = 32'd19;
        wr1_valid = 1'b1; wr1_addr = 4'd7; wr1_data = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("cont_gnt0", 64'(wr0_ready), 64'((i % 2) == 0));
            chk("cont_gnt1", 64'(wr1_ready), 64'((i % 2) == 1));
            if (i > 0) chk("cont_we", 64'(rb_we), 64'd1);
            if ((i % 2) == 0) push_wr(4'd4, 32'd19);
            else              push_wr(4'd7, 32'd5);
            next_cycle();
        end
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        @(negedge clk);
        chk("cont_we_last", 64'(rb_we), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("idle_we", 64'(rb_we), 64'd0);
        chk("idle_hold_dest", 64'(rb_dest), 64'd7);

        // Single write
        next_cycle();
        wr0_valid = 1'b1; wr0_addr = 4'd1; wr0_data = 32'd1;
        @(negedge clk);
        chk("single_rdy0", 64'(wr0_ready), 64'd1);
        chk("single_rdy1", 64'(wr1_ready), 64'd0);
        push_wr(4'd1, 32'd1);
        next_cycle();
        wr0_valid = 1'b0;
        @(negedge clk);
        chk("single_we", 64'(rb_we), 64'd1);

        // Scoreboard: reserve 4, re-reserve rejected, write clears
        next_cycle();
        rsv_valid = 1'b1; rsv_addr = 4'd4; chk_addr1 = 4'd4;
        @(negedge clk);
        chk("rsv4_ready", 64'(rsv_ready), 64'd1);
        chk("rsv4_busy_before", 64'(chk_busy1), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("rsv4_busy", 64'(chk_busy1), 64'd1);
        chk("rsv4_pend", 64'(pend_cnt), 64'd1);
        chk("rsv4_again_ready", 64'(rsv_ready), 64'd0);
        next_cycle();
        rsv_valid = 1'b0;
        wr0_valid = 1'b1; wr0_addr = 4'd4; wr0_data = 32'hA4;
        @(negedge clk);
        chk("w4_ready", 64'(wr0_ready), 64'd1);
        push_wr(4'd4, 32'hA4);
        next_cycle();
        wr0_valid = 1'b0;
        @(negedge clk);
        chk("w4_busy_n1", 64'(chk_busy1), 64'd1);
        chk("w4_pend_n1", 64'(pend_cnt), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("w4_busy_n2", 64'(chk_busy1), 64'd0);
        chk("w4_pend_n2", 64'(pend_cnt), 64'd0);

        // Flush overrides a same-cycle reservation
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] addrs [3];
            addrs = '{4'd2, 4'd3, 4'd9};
            next_cycle();
            rsv_valid = 1'b1; rsv_addr = addrs[i];
        end
        next_cycle();
        rsv_valid = 1'b1; rsv_addr = 4'd5; flush = 1'b1;
        chk_addr1 = 4'd2; chk_addr2 = 4'd9;
        @(negedge clk);
        chk("pre_flush_pend", 64'(pend_cnt), 64'd3);
        chk("pre_flush_busy2", 64'(chk_busy2), 64'd1);
        chk("flush_rsv_ready", 64'(rsv_ready), 64'd0);
        next_cycle();
        rsv_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_pend", 64'(pend_cnt), 64'd0);
        chk("flush_busy1", 64'(chk_busy1), 64'd0);
        chk("flush_busy2", 64'(chk_busy2), 64'd0);
        chk_addr1 = 4'd5; chk_addr2 = 4'd3;
        #1;
        chk("flush_busy5", 64'(chk_busy1), 64'd0);
        chk("flush_busy3", 64'(chk_busy2), 64'd0);

        // Unreserved write committed, pending count untouched
        next_cycle();
        rsv_valid = 1'b1; rsv_addr = 4'd6;
        next_cycle();
        rsv_valid = 1'b0;
        wr1_valid = 1'b1; wr1_addr = 4'd0; wr1_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("unrsv_ready1", 64'(wr1_ready), 64'd1);
        push_wr(4'd0, 32'hFFFF_FFFF);
        next_cycle();
        wr1_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("unrsv_pend", 64'(pend_cnt), 64'd1);
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;

        // Reset in the middle of a write
        next_cycle();
        wr0_valid = 1'b1; wr0_addr = 4'd10; wr0_data = 32'hA5;
        rsv_valid = 1'b1; rsv_addr = 4'd11; chk_addr1 = 4'd11;
        push_wr(4'd10, 32'hA5);
        next_cycle();
        rsv_valid = 1'b0;
        wr0_addr = 4'd12; wr0_data = 32'h77;
        @(negedge clk);
        chk("mid_we", 64'(rb_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we",   64'(rb_we),    64'd0);
        chk("mid_rst_dest", 64'(rb_dest),  64'd0);
        chk("mid_rst_din",  64'(rb_din),   64'd0);
        chk("mid_rst_pend", 64'(pend_cnt), 64'd0);
        chk("mid_rst_busy", 64'(chk_busy1), 64'd0);
        wr0_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        wr0_valid = 1'b1; wr0_addr = 4'd13; wr0_data = 32'h13;
        wr1_valid = 1'b1; wr1_addr = 4'd14; wr1_data = 32'h14;
        @(negedge clk);
        chk("post_rst_rdy0", 64'(wr0_ready), 64'd1);
        chk("post_rst_rdy1", 64'(wr1_ready), 64'd0);
        push_wr(4'd13, 32'h13);
        next_cycle();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_we", 64'(rb_we), 64'd1);

        repeat (3) next_cycle();
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
